// File: rtl/dfp_addsub_sched.sv
// dfp_addsub_sched
//   Shares one pipelined 96-bit DFP add/sub unit among NREQ requesters.
//   A round-robin arbiter issues at most one operation per enabled cycle.
//   A LAT+1 deep tag pipe follows each operation through the unit, so the
//   result can be returned with the index of the requester that issued it.
//   Per-requester credit counters cap the number of operations in flight.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   ce                clock enable, shared with the add/sub unit
//   req               per-requester level request, held until granted
//   req_op/rm/a/b     per-requester operation, rounding mode and operands
//   gnt               one-hot grant; the granted operands are taken this cycle
//   pipe_op/rm/a/b    registered operation presented to the unit
//   pipe_o            unit result
//   res_vld/id/o      result pulse, owning requester, and result data
//   busy              at least one operation in flight
module dfp_addsub_sched #(
    parameter int NREQ   = 4,
    parameter int LAT    = 20,
    parameter int MAXOUT = 4,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_op,
    input  logic [3*NREQ-1:0]   req_rm,
    input  logic [96*NREQ-1:0]  req_a,
    input  logic [96*NREQ-1:0]  req_b,
    output logic [NREQ-1:0]     gnt,
    output logic                pipe_op,
    output logic [2:0]          pipe_rm,
    output logic [95:0]         pipe_a,
    output logic [95:0]         pipe_b,
    input  logic [95:0]         pipe_o,
    output logic                res_vld,
    output logic [IDW-1:0]      res_id,
    output logic [95:0]         res_o,
    output logic                busy
);

    localparam logic [3:0] MAX_C = 4'(MAXOUT);

    logic [IDW-1:0] rr;
    logic [3:0]     credit [NREQ];
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic           sel_op;
    logic [2:0]     sel_rm;
    logic [95:0]    sel_a;
    logic [95:0]    sel_b;
    logic [LAT:0]   tag_vld;
    logic [IDW-1:0] tag_id [LAT+1];
    logic [NREQ-1:0] ret;

    // Round-robin search starting at rr. The grant is combinational so the
    // requester sees it in the same cycle its operands are captured.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx     = 0;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        sel_op  = 1'b0;
        sel_rm  = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int j = 0; j < NREQ; j++) begin
            idx = (int'(rr) + j) % NREQ;
            if (!gnt_any && req[idx] && ce && !rst && credit[idx] < MAX_C) begin
                gnt[idx] = 1'b1;
                gnt_any  = 1'b1;
                gnt_idx  = IDW'(idx);
                sel_op   = req_op[idx];
                sel_rm   = req_rm[3*idx +: 3];
                sel_a    = req_a[96*idx +: 96];
                sel_b    = req_b[96*idx +: 96];
            end
        end
    end

    // The last tag stage lines up with the unit output; ce gates the pulse
    // because a frozen pipe must not return the same result twice.
    assign res_vld = ce & tag_vld[LAT];
    assign res_id  = tag_id[LAT];
    assign res_o   = pipe_o;
    assign busy    = |tag_vld;

    always_comb begin
        ret = '0;
        if (res_vld) ret[res_id] = 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr      <= '0;
            pipe_op <= 1'b0;
            pipe_rm <= '0;
            pipe_a  <= '0;
            pipe_b  <= '0;
            tag_vld <= '0;
            // NOTE: the id stages are reset along with the valids so res_id reads 0 out of reset.
            for (int k = 0; k <= LAT; k++) tag_id[k] <= '0;
            for (int k = 0; k < NREQ; k++) credit[k] <= '0;
        end else if (ce) begin
            tag_vld   <= {tag_vld[LAT-1:0], gnt_any};
            tag_id[0] <= gnt_idx;
            for (int k = 1; k <= LAT; k++) tag_id[k] <= tag_id[k-1];
            if (gnt_any) begin
                rr      <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                pipe_op <= sel_op;
                pipe_rm <= sel_rm;
                pipe_a  <= sel_a;
                pipe_b  <= sel_b;
            end
            // A grant and a return for the same requester cancel out.
            for (int k = 0; k < NREQ; k++) begin
                assert (!(ret[k] && credit[k] == 4'd0));
                credit[k] <= credit[k] + {3'b000, gnt[k]} - {3'b000, ret[k]};
            end
        end
    end

endmodule

// File: tb/tb_dfp_addsub_sched.sv
// tb_dfp_addsub_sched
//   Drives dfp_addsub_sched with directed scenarios followed by a randomized
//   phase. A stand-in for the add/sub unit (LAT ce-cycle delay of a simple
//   arithmetic function) closes the loop on pipe_*/pipe_o. A queue-based
//   model of outstanding operations predicts grants, result timing, result
//   ownership and data, and busy every cycle.
module tb_dfp_addsub_sched;

    localparam int NREQ   = 4;
    localparam int LAT    = 20;
    localparam int MAXOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_op;
    logic [3*NREQ-1:0] req_rm;
    logic [96*NREQ-1:0] req_a;
    logic [96*NREQ-1:0] req_b;
    logic [NREQ-1:0]   gnt;
    logic              pipe_op;
    logic [2:0]        pipe_rm;
    logic [95:0]       pipe_a;
    logic [95:0]       pipe_b;
    logic [95:0]       pipe_o;
    logic              res_vld;
    logic [1:0]        res_id;
    logic [95:0]       res_o;
    logic              busy;

    always #5 clk = ~clk;

    dfp_addsub_sched #(.NREQ(NREQ), .LAT(LAT), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .req(req), .req_op(req_op), .req_rm(req_rm), .req_a(req_a), .req_b(req_b),
        .gnt(gnt),
        .pipe_op(pipe_op), .pipe_rm(pipe_rm), .pipe_a(pipe_a), .pipe_b(pipe_b),
        .pipe_o(pipe_o),
        .res_vld(res_vld), .res_id(res_id), .res_o(res_o), .busy(busy)
    );

    // Stand-in unit: distinct, op/rm-dependent results with the real latency.
    function automatic logic [95:0] unit_fn(input logic op, input logic [2:0] rm,
                                            input logic [95:0] a, input logic [95:0] b);
        return (op ? a - b : a + b) ^ {93'd0, rm};
    endfunction

    logic [95:0] unit_pipe [LAT];
    always @(posedge clk) begin
        if (ce) begin
            unit_pipe[0] <= unit_fn(pipe_op, pipe_rm, pipe_a, pipe_b);
            for (int i = 1; i < LAT; i++) unit_pipe[i] <= unit_pipe[i-1];
        end
    end
    assign pipe_o = unit_pipe[LAT-1];

    // Reference model: each in-flight op counts down the ce cycles it still
    // needs; results leave in issue order.
    typedef struct {
        int          id;
        logic [95:0] res;
        int          rem;
    } flight_t;

    flight_t         inflight[$];
    int              m_rr;
    int              m_credit [NREQ];
    logic [NREQ-1:0] exp_gnt;
    int              dut_log[$];
    int              dut_rets;
    int              same_cycle_hits;
    int              tests = 0;
    int              fails = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [NREQ-1:0] g;
        logic            exp_vld;
        int              idx;
        flight_t         e;
        g       = '0;
        exp_vld = 1'b0;
        chk("busy", busy, inflight.size() > 0);
        if (ce && !rst) begin
            for (int j = 0; j < NREQ; j++) begin
                idx = (m_rr + j) % NREQ;
                if (g == '0 && req[idx] && m_credit[idx] < MAXOUT) g[idx] = 1'b1;
            end
        end
        exp_gnt = g;
        chk("gnt", gnt, g);
        for (int i = 0; i < NREQ; i++) if (gnt[i]) dut_log.push_back(i);
        if (res_vld) dut_rets++;
        if (gnt[0] && res_vld && res_id == 2'd0) same_cycle_hits++;
        if (ce) begin
            foreach (inflight[i]) inflight[i].rem--;
            if (inflight.size() > 0 && inflight[0].rem == 0) begin
                exp_vld = 1'b1;
                e = inflight.pop_front();
                chk("res_id", res_id, 96'(e.id));
                chk("res_o", res_o, e.res);
                m_credit[e.id]--;
            end
        end
        chk("res_vld", res_vld, exp_vld);
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                e.id  = i;
                e.res = unit_fn(req_op[i], req_rm[3*i +: 3], req_a[96*i +: 96], req_b[96*i +: 96]);
                e.rem = LAT + 1;
                inflight.push_back(e);
                m_credit[i]++;
                m_rr = (i + 1) % NREQ;
            end
        end
        if (rst) begin
            inflight.delete();
            m_rr = 0;
            for (int i = 0; i < NREQ; i++) m_credit[i] = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic op, input logic [2:0] rm,
                           input logic [95:0] a, input logic [95:0] b);
        req[i]              = 1'b1;
        req_op[i]           = op;
        req_rm[3*i +: 3]    = rm;
        req_a[96*i +: 96]   = a;
        req_b[96*i +: 96]   = b;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'(($urandom & 1)), 3'($urandom_range(0, 7)),
                {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
    endtask

    task automatic drop_granted();
        req = req & ~exp_gnt;
    endtask

    task automatic drain();
        req = '0;
        ce  = 1'b1;
        for (int n = 0; n < LAT + 4 && inflight.size() > 0; n++) step();
        chk("drain_empty", inflight.size() == 0, 1'b1);
        step();
    endtask

    task automatic reset_pulse();
        req = '0;
        ce  = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int fair_exp [8];
        int grants;
        fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
        rst = 1'b1; ce = 1'b1;
        req = '0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
        m_rr = 0; dut_rets = 0; same_cycle_hits = 0;
        for (int i = 0; i < NREQ; i++) m_credit[i] = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step();
        chk("rst_pipe_op", pipe_op, 1'b0);
        chk("rst_pipe_rm", pipe_rm, 3'd0);
        chk("rst_pipe_a", pipe_a, 96'd0);
        chk("rst_pipe_b", pipe_b, 96'd0);
        chk("rst_res_id", res_id, 2'd0);
        rst = 1'b0;

        // Single add from requester 1
        set_req(1, 1'b0, 3'd0, 96'h15, 96'h225);
        step();
        chk("single_gnt", dut_log.size() == 1 && dut_log[0] == 1, 1'b1);
        drop_granted();
        drain();

        // Fairness with all requesters held, from rr = 0
        reset_pulse();
        dut_log.delete();
        for (int i = 0; i < NREQ; i++) rand_req(i);
        repeat (8) step();
        req = '0;
        chk("fair_count", 96'(dut_log.size()), 96'd8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++)
            chk("fair_order", 96'(dut_log[i]), 96'(fair_exp[i]));
        drain();

        // Credit cap with only requester 2
        dut_log.delete();
        grants = 0;
        for (int n = 0; n < LAT + 1; n++) begin
            rand_req(2);
            step();
        end
        grants = dut_log.size();
        chk("cap_grants", 96'(grants), 96'(MAXOUT));
        for (int n = 0; n < 8; n++) begin
            rand_req(2);
            step();
        end
        chk("cap_regrant", 96'(dut_log.size()) > 96'(MAXOUT), 1'b1);
        drain();

        // Enable gaps while operations are in flight
        rand_req(0); rand_req(3);
        for (int n = 0; n < 12; n++) begin
            ce = 1'(n % 2 == 0);
            step();
            drop_granted();
        end
        ce = 1'b1;
        for (int n = 0; n < 2 * LAT + 10; n++) begin
            ce = 1'($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        // Reset with three operations in flight
        rand_req(0); rand_req(1); rand_req(2);
        for (int n = 0; n < 5; n++) begin
            step();
            drop_granted();
        end
        chk("mid_busy", busy, 1'b1);
        reset_pulse();
        dut_rets = 0;
        repeat (LAT + 2) step();
        chk("mid_no_ret", 96'(dut_rets), 96'd0);
        rand_req(3);
        step();
        chk("mid_credit_free", gnt, 4'b1000);
        drop_granted();
        drain();

        // Grant and return for requester 0 in the same cycle
        reset_pulse();
        rand_req(0);
        step();
        drop_granted();
        for (int n = 0; n < LAT; n++) begin
            if (n == 5) rand_req(1);
            step();
            drop_granted();
        end
        rand_req(0);
        same_cycle_hits = 0;
        step();
        drop_granted();
        chk("same_cycle", 96'(same_cycle_hits), 96'd1);
        drain();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            ce = 1'($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && $urandom_range(0, 1) == 1) rand_req(i);
            step();
            drop_granted();
        end
        drain();
        chk("end_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
